// File: rtl/shift_register_param_pkg.sv
// shift_register_param_pkg: mode encoding and per-stage next-value select shared by the shift register.
package shift_register_param_pkg;
    typedef logic [2:0] mode_t;
    localparam mode_t HOLD     = 3'd0;
    localparam mode_t SHIFT_UP = 3'd1;
    localparam mode_t SHIFT_DN = 3'd2;
    localparam mode_t ROT_UP   = 3'd3;
    localparam mode_t ROT_DN   = 3'd4;
    localparam mode_t LOAD     = 3'd5;
    localparam mode_t CLEAR    = 3'd6;
    typedef enum logic [2:0] {SEL_HOLD, SEL_LO, SEL_HI, SEL_PAR, SEL_ZERO} sel_t;
    // Shift and rotate share a select; only the end-stage feed differs.
    function automatic sel_t stage_sel(input logic en, input mode_t mode);
        return !en ? SEL_HOLD :
               (mode == SHIFT_UP || mode == ROT_UP) ? SEL_LO :
               (mode == SHIFT_DN || mode == ROT_DN) ? SEL_HI :
               (mode == LOAD) ? SEL_PAR :
               (mode == CLEAR) ? SEL_ZERO : SEL_HOLD;
    endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one WIDTH-bit stage choosing hold, lower/upper neighbour, parallel input or zero.
module shift_stage
    import shift_register_param_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  sel_t             i_sel,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_par,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    always_comb begin
        w_next = (i_sel == SEL_LO)   ? i_lo :
                 (i_sel == SEL_HI)   ? i_hi :
                 (i_sel == SEL_PAR)  ? i_par :
                 (i_sel == SEL_ZERO) ? '0 : r_q;
    end
    always_ff @(posedge clk) begin
        if (reset) r_q <= '0;
        else       r_q <= w_next;
    end
    assign o_q = r_q;
endmodule

// File: rtl/shift_register_param.sv
// shift_register_param: bidirectional WIDTH x DEPTH shift register with load, rotate, clear and fill tracking.
module shift_register_param
    import shift_register_param_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           ser_in_up,
    input  logic [WIDTH-1:0]           ser_in_dn,
    input  logic [DEPTH*WIDTH-1:0]     par_in,
    output logic [WIDTH-1:0]           ser_out_up,
    output logic [WIDTH-1:0]           ser_out_dn,
    output logic [DEPTH*WIDTH-1:0]     par_out,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic                       full
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    sel_t             w_sel;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [CW-1:0]    r_fill;
    logic [CW-1:0]    w_fill_next;
    assign w_sel = stage_sel(en, mode);
    // Index g holds stage g+1; end stages take the serial input or the wrap tap.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] w_lo;
        logic [WIDTH-1:0] w_hi;
        if (g == 0) begin : g_first
            assign w_lo = (mode == ROT_UP) ? w_q[DEPTH-1] : ser_in_up;
        end else begin : g_lo
            assign w_lo = w_q[g-1];
        end
        if (g == DEPTH-1) begin : g_last
            assign w_hi = (mode == ROT_DN) ? w_q[0] : ser_in_dn;
        end else begin : g_hi
            assign w_hi = w_q[g+1];
        end
        shift_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .reset (reset),
            .i_sel (w_sel),
            .i_lo  (w_lo),
            .i_hi  (w_hi),
            .i_par (par_in[(g+1)*WIDTH-1 -: WIDTH]),
            .o_q   (w_q[g])
        );
        assign par_out[(g+1)*WIDTH-1 -: WIDTH] = w_q[g];
    end
    always_comb begin
        w_fill_next = (mode == SHIFT_UP || mode == SHIFT_DN) ?
                          ((r_fill == FULL_CNT) ? r_fill : r_fill + 1'b1) :
                      (mode == LOAD)  ? FULL_CNT :
                      (mode == CLEAR) ? '0 : r_fill;
    end
    always_ff @(posedge clk) begin
        if (reset)   r_fill <= '0;
        else if (en) r_fill <= w_fill_next;
    end
    assign ser_out_up = w_q[DEPTH-1];
    assign ser_out_dn = w_q[0];
    assign fill_count = r_fill;
    assign full       = (r_fill == FULL_CNT);
endmodule

// File: tb/tb_shift_register_param.sv
// tb_shift_register_param: directed vectors feed an expected-value queue; a negedge monitor pops and compares.
module tb_shift_register_param;
    import shift_register_param_pkg::*;
    localparam int W = 4;
    localparam int D = 8;
    typedef struct {
        logic [31:0] par;
        logic [3:0]  fill;
    } exp_t;
    logic          clk = 1'b0;
    logic          reset, en;
    logic [2:0]    mode;
    logic [W-1:0]  ser_in_up, ser_in_dn, ser_out_up, ser_out_dn;
    logic [31:0]   par_in, par_out;
    logic [3:0]    fill_count;
    logic          full;
    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;

    shift_register_param #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .ser_in_up  (ser_in_up),
        .ser_in_dn  (ser_in_dn),
        .par_in     (par_in),
        .ser_out_up (ser_out_up),
        .ser_out_dn (ser_out_dn),
        .par_out    (par_out),
        .fill_count (fill_count),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("par_out", par_out, e.par);
            cmp("fill_count", {28'd0, fill_count}, {28'd0, e.fill});
            cmp("full", {31'd0, full}, {31'd0, e.fill == 4'd8});
            cmp("ser_out_up", {28'd0, ser_out_up}, {28'd0, e.par[31:28]});
            cmp("ser_out_dn", {28'd0, ser_out_dn}, {28'd0, e.par[3:0]});
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic [3:0] su, input logic [3:0] sd, input logic [31:0] p);
        reset = r; en = e; mode = m; ser_in_up = su; ser_in_dn = sd; par_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] p, input logic [3:0] f);
        exp_t e;
        e.par = p;
        e.fill = f;
        q.push_back(e);
    endtask

    initial begin
        cyc(1, 1, LOAD, 0, 0, 32'hFFFF_FFFF);           chk(32'h0000_0000, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, SHIFT_UP, 4'(i), 0, 0);
            if (i == 3) chk(32'h0000_0123, 3);
        end
        chk(32'h1234_5678, 8);
        cyc(0, 1, SHIFT_UP, 4'd9, 0, 0);                chk(32'h2345_6789, 8);
        cyc(0, 1, LOAD, 0, 0, 32'h8765_4321);           chk(32'h8765_4321, 8);
        cyc(0, 1, ROT_UP, 4'hE, 4'hE, 0);               chk(32'h7654_3218, 8);
        cyc(0, 1, ROT_UP, 4'hE, 4'hE, 0);
        cyc(0, 1, ROT_UP, 4'hE, 4'hE, 0);               chk(32'h5432_1876, 8);
        cyc(0, 1, ROT_DN, 4'hE, 4'hE, 0);               chk(32'h6543_2187, 8);
        cyc(0, 1, ROT_DN, 4'hE, 4'hE, 0);
        cyc(0, 1, ROT_DN, 4'hE, 4'hE, 0);               chk(32'h8765_4321, 8);
        for (int i = 0; i < 5; i++) cyc(0, 0, SHIFT_DN, 0, 4'hF, 0);
        chk(32'h8765_4321, 8);
        cyc(0, 1, SHIFT_DN, 0, 4'hF, 0);                chk(32'hF876_5432, 8);
        cyc(0, 1, CLEAR, 0, 0, 32'hFFFF_FFFF);          chk(32'h0000_0000, 0);
        cyc(0, 1, SHIFT_UP, 4'hA, 0, 0);
        cyc(0, 1, SHIFT_UP, 4'hB, 0, 0);
        cyc(0, 1, SHIFT_UP, 4'hC, 0, 0);                chk(32'h0000_0ABC, 3);
        cyc(0, 1, CLEAR, 0, 0, 0);                      chk(32'h0000_0000, 0);
        cyc(0, 1, 3'd7, 4'h3, 4'h3, 32'hFFFF_FFFF);
        cyc(0, 1, 3'd7, 4'h3, 4'h3, 32'hFFFF_FFFF);     chk(32'h0000_0000, 0);
        cyc(0, 1, SHIFT_DN, 0, 4'h5, 0);                chk(32'h5000_0000, 1);
        cyc(0, 1, 3'd7, 4'h3, 4'h3, 32'hFFFF_FFFF);
        cyc(0, 1, 3'd7, 4'h3, 4'h3, 32'hFFFF_FFFF);     chk(32'h5000_0000, 1);
        cyc(0, 1, HOLD, 4'h3, 4'h3, 32'hFFFF_FFFF);     chk(32'h5000_0000, 1);
        for (int i = 1; i <= 4; i++) cyc(0, 1, SHIFT_UP, 4'(i), 0, 0);
        chk(32'h0000_1234, 5);
        cyc(1, 1, SHIFT_UP, 4'h5, 0, 0);                chk(32'h0000_0000, 0);
        cyc(0, 1, SHIFT_UP, 4'h7, 0, 0);                chk(32'h0000_0007, 1);
        cyc(0, 1, SHIFT_UP, 4'h6, 0, 0);                chk(32'h0000_0076, 2);
        cyc(0, 1, HOLD, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
